scan_chain_sequencer: RTL
=========================

# scan_chain_sequencer

Drives the scan port of a parallel-load shift register stage: it takes a parallel test vector over a valid/ready handshake and serialises it onto `scan_enable`/`scan_in`. It simultaneously unloads the stage's previous contents from `scan_out`, then pulses the stage's parallel `enable` for one capture cycle. It sits directly upstream of the scan register (driving it) and feeds the unloaded response to the test-result collector.

## Interface
- `CHAIN_LEN`, default 8: scan chain length in bits (≥2); equals the downstream register `WIDTH`.
- `MISR_POLY`, default 8'hB8 (width CHAIN_LEN): feedback taps, used only with `SCAN_SEQ_MISR_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `vec_valid` in 1: test vector offered.
- `vec_ready` out 1: sequencer accepts the vector.
- `vec_data` in CHAIN_LEN: vector to load into the chain; bit k lands in chain bit k.
- `scan_enable` out 1: shift strobe to the chain.
- `scan_in` out 1: serial data to the chain.
- `scan_out` in 1: chain MSB.
- `capture_en` out 1: one-cycle parallel-load strobe to the chain's `enable`.
- `resp_valid` out 1: unloaded response available.
- `resp_ready` in 1: collector accepts the response.
- `resp_data` out CHAIN_LEN: chain contents unloaded during the last shift.
- `busy` out 1: high in any state other than IDLE.
- `misr_sig` out CHAIN_LEN: present only with `SCAN_SEQ_MISR_EN`.

## Operation
- FSM states: IDLE, SHIFT, CAPTURE, RESP.
- IDLE: `vec_ready`=1. On `vec_valid & vec_ready`, load `vec_data` into `vec_sr`, clear the bit counter, and go to SHIFT.
- SHIFT, per cycle:
  - `scan_enable`=1 and `scan_in`=`vec_sr[CHAIN_LEN-1]`.
  - `vec_sr` shifts left; `resp_sr` <= {`resp_sr[CHAIN_LEN-2:0]`, `scan_out`}.
  - Counter increments. When the counter reaches CHAIN_LEN-1, go to CAPTURE.
- CAPTURE: `scan_enable`=0 and `capture_en`=1 for exactly one cycle, then go to RESP.
- RESP: `resp_valid`=1 and `resp_data`=`resp_sr`, held stable until `resp_ready`. Then return to IDLE. `vec_ready`=0 here; responses are never dropped.
- The response unloaded during a shift is the chain state captured by the previous pattern. The first response after reset is all-zero if the chain was reset.
- MSB-first serialisation: after CHAIN_LEN shifts, chain bit k equals `vec_data[k]` and `resp_data` bit k equals old chain bit k.
- Outputs are registered. `scan_enable`, `scan_in` and `capture_en` are decoded from registered state only, never combinationally from inputs.

## Timing
- Reset values: state=IDLE, `vec_ready`=1 once reset deasserts (0 during reset), `scan_enable`=0, `scan_in`=0, `capture_en`=0, `resp_valid`=0, `resp_data`=0, `busy`=0, `misr_sig`=0.
- Handshake at edge T puts `scan_enable` high in cycles T+1 … T+CHAIN_LEN, `capture_en` high in T+CHAIN_LEN+1, and `resp_valid` high from T+CHAIN_LEN+2.
- Minimum pattern period is CHAIN_LEN+3 cycles, with `resp_ready` tied high.
- `scan_out` is sampled on the same edge at which the chain shifts.
- `rst` mid-SHIFT aborts immediately. All outputs go to reset values asynchronously and the partial vector is discarded.
- `vec_valid` while busy is ignored, since `vec_ready`=0; the upstream source holds it.
- `resp_ready` asserted while `resp_valid`=0 has no effect.

## Configuration
- `SCAN_SEQ_MISR_EN` defined: the `misr_sig` port exists. On each RESP handshake, `misr_sig` <= {`misr_sig[CHAIN_LEN-2:0]`,1'b0} ^ (`misr_sig[CHAIN_LEN-1]` ? `MISR_POLY` : 0) ^ `resp_data`. Only `rst` clears it.
- Undefined: no `misr_sig` port and no MISR logic. Behaviour is otherwise identical.

## Structure
- Shared package `scan_pkg`: state enum typedef (IDLE/SHIFT/CAPTURE/RESP) and the default `MISR_POLY` constant.
- Counter width is a local `$clog2(CHAIN_LEN)`.
- One sub-module: `scan_misr`, instantiated only under the macro.

## Test plan
- After reset, with `vec_data`=8'hA5 and `resp_ready`=1: `scan_in` sequence is 1,0,1,0,0,1,0,1 over 8 `scan_enable` cycles, then one `capture_en`, then `resp_data`=8'h00.
- Back-to-back patterns 8'hA5 then 8'h3C against the real chain, with `data_in` held at 8'hF0: the second response is 8'hF0, confirming the capture value was unloaded.
- Hold `resp_ready`=0 for 5 cycles in RESP: `resp_valid` and `resp_data` stay stable, `vec_ready`=0, and a `vec_valid` pulse is ignored.
- Assert `rst` at shift cycle 4: `scan_enable`, `busy` and `resp_valid` drop immediately, and the next vector starts a full 8-cycle shift.
- `CHAIN_LEN`=2, vector 2'b10: `scan_enable` is high exactly 2 cycles, and the end-to-end latency from handshake to `resp_valid` is 4 cycles.
- With `SCAN_SEQ_MISR_EN`, responses 8'h01 then 8'h80: `misr_sig`=8'h01, then 8'h82, then 8'hB8^(8'h82<<1 truncated)^0 on the next zero response.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [7:0] MISR_POLY_DEFAULT = 8'hB8;

endpackage

// File: rtl/scan_misr.sv
// Multiple-input signature register that folds each accepted response into a running signature.
module scan_misr #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   POLY  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (update) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
        end
    end

endmodule

// File: rtl/scan_chain_sequencer.sv
// Serialises a test vector into a scan chain while unloading the previous capture, then strobes one capture.
// Optional response signature (misr_sig port) is enabled by defining SCAN_SEQ_MISR_EN.
module scan_chain_sequencer
    import scan_pkg::*;
#(
    parameter int                     CHAIN_LEN = 8,
    parameter logic [CHAIN_LEN-1:0]   MISR_POLY = CHAIN_LEN'(MISR_POLY_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [CHAIN_LEN-1:0] vec_data,
    output logic                 scan_enable,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 capture_en,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 busy
`ifdef SCAN_SEQ_MISR_EN
    ,
    output logic [CHAIN_LEN-1:0] misr_sig
`endif
);

    localparam int                CNT_W    = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CHAIN_LEN-1:0]  vec_sr;
    logic [CHAIN_LEN-1:0]  resp_sr;
    logic                  ready_q;
    logic                  vec_hs;

    assign vec_hs = vec_valid && ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vec_hs) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // scan_out is sampled on the same edge the chain shifts, so resp_sr fills MSB-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_sr  <= '0;
            resp_sr <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (vec_hs) begin
                        vec_sr <= vec_data;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    vec_sr  <= {vec_sr[CHAIN_LEN-2:0], 1'b0};
                    resp_sr <= {resp_sr[CHAIN_LEN-2:0], scan_out};
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign vec_ready   = ready_q;
    assign scan_enable = (state == SHIFT);
    assign scan_in     = (state == SHIFT) ? vec_sr[CHAIN_LEN-1] : 1'b0;
    assign capture_en  = (state == CAPTURE);
    assign resp_valid  = (state == RESP);
    assign resp_data   = resp_sr;
    assign busy        = (state != IDLE);

`ifdef SCAN_SEQ_MISR_EN
    scan_misr #(
        .WIDTH (CHAIN_LEN),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .update (resp_valid && resp_ready),
        .data   (resp_sr),
        .sig    (misr_sig)
    );
`endif

endmodule
